muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle RV32M execute unit that computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and produces the 32-bit write-back value for the register file's `wd` port. It sits directly upstream of the register file, beside the ALU on the write-back mux. Control holds the PC and suppresses `reg_write` while `busy` is high. On `done`, control writes `result` into `rd`.

## Interface
- `XLEN`, default 32: operand/result width; only 32 is supported.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  request; sampled only in IDLE.
- `funct3`  in  3  operation select:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `a`  in  32  rs1 value (dividend / multiplicand).
- `b`  in  32  rs2 value (divisor / multiplier).
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  registered one-cycle pulse; `result` is valid while it is high.
- `result`  out  32  last completed result; held until the next completion.

## Operation
- States: IDLE, CALC, FINISH.
- IDLE → CALC on an accepted `start` (normal iterative op).
  - `a`, `b` and `funct3` are captured at acceptance; later input changes are ignored.
  - A 5-bit counter is cleared.
- IDLE → FINISH directly for special cases:
  - divide by zero;
  - signed overflow (DIV/REM with `a`=0x80000000, `b`=0xFFFFFFFF);
  - all multiplies when MULDIV_FAST_MUL_EN is defined.
- CALC: one iteration per clock, counter 0..31. At counter = 31 → FINISH.
- FINISH: applies the sign fix, registers `result`, pulses `done`, returns to IDLE.
- Signedness: operands are converted to unsigned magnitudes at acceptance.
  - `a` is signed for MULH, MULHSU, DIV, REM.
  - `b` is signed for MULH, DIV, REM.
  - The magnitude of 0x80000000 is 2^31 and fits unsigned 32-bit.
- Multiply: 32-step shift-add into a 64-bit accumulator.
  - Negate the 64-bit product if the operand signs differ (signed positions only).
  - MUL takes bits [31:0]; MULH/MULHSU/MULHU take bits [63:32].
- Divide: 32-step restoring, one quotient bit per step, 33-bit partial remainder.
  - Quotient is negated when the signs differ.
  - Remainder takes the sign of the dividend.
- Special results, per the RISC-V spec:
  - DIV/DIVU by 0 → 0xFFFFFFFF.
  - REM/REMU by 0 → `a`.
  - Overflow: DIV → 0x80000000, REM → 0.
- `start` while busy is ignored; there is no queueing and no error flag.
- Reset (at any time, including mid-CALC):
  - state IDLE, `busy`=0, `done`=0, `result`=0, counter=0, accumulators=0;
  - the aborted op produces no `done`.

## Timing
- Accept edge E0 = the rising edge on which `start`=1 in IDLE.
- Iterative op:
  - `busy` high for the 33 cycles after E0;
  - `done`=1 and `result` valid in the cycle after edge E0+33 (latency 33).
- Special-case op: FINISH at E1, `done` high in the cycle after E1 (latency 1).
- `done` coincides with IDLE and `busy`=0, so back-to-back issue is allowed: `start` may be accepted on the edge that ends the `done` cycle.
- `result` changes only at FINISH edges or on reset.

## Configuration
- Macro: `MULDIV_FAST_MUL_EN`.
- When defined:
  - all four multiply ops use a combinational 64-bit signed/unsigned product;
  - they go IDLE → FINISH with latency 1.
- When undefined:
  - multiplies use the 32-step shift-add path with latency 33;
  - no wide multiplier is inferred.
- Division behaviour is identical either way.

## Test plan
- MUL `a`=7, `b`=0xFFFFFFFD (−3):
  - `result`=0xFFFFFFEB;
  - `done` 33 cycles after accept (1 with the macro defined).
- MULH `a`=`b`=0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2. Each with latency 33.
- DIV 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, both latency 1. DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM of the same → 0, both latency 1.
- Start/busy handshake:
  - `start` pulsed again mid-CALC with different operands → ignored; the first result is unchanged.
  - `start` asserted during the `done` cycle → accepted; the next result follows 33 cycles later.
- Reset mid-op:
  - assert `rst` at counter = 10 → `busy`, `done`, `result` go 0 immediately (asynchronously);
  - no `done` follows;
  - the next op after release completes normally.

Source files
------------

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: shift-add multiply, restoring divide, RISC-V special cases.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle 64-bit product.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_t              state_q, state_d;
   logic [4:0]          cnt_q, cnt_d;
   logic [2:0]          op_q, op_d;
   logic                neg_q, neg_d;
   logic [XLEN-1:0]     opnd_q, opnd_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     result_q, result_d;
   logic                done_q, done_d;

   logic                a_sgn, b_sgn, a_neg, b_neg;
   logic                is_div, is_rem, div_zero, div_ovf, special;
   logic [XLEN-1:0]     a_mag, b_mag;
   logic [XLEN:0]       mul_sum, div_shift;
   logic                div_ge;
   logic [2*XLEN-1:0]   mul_next, div_next, prod_fix;
   logic [XLEN-1:0]     div_half;

   function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
      return (~v) + XLEN'(1);
   endfunction

   function automatic logic [2*XLEN-1:0] neg_2w(input logic [2*XLEN-1:0] v);
      return (~v) + (2*XLEN)'(1);
   endfunction

   // Operand decode: signedness per op, magnitudes and the cases that skip iteration
   always_comb begin
      a_sgn    = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3[2] && !funct3[0]);
      b_sgn    = (funct3 == 3'b001) || (funct3[2] && !funct3[0]);
      a_neg    = a_sgn && a[XLEN-1];
      b_neg    = b_sgn && b[XLEN-1];
      a_mag    = a_neg ? neg_w(a) : a;
      b_mag    = b_neg ? neg_w(b) : b;
      is_div   = funct3[2];
      is_rem   = funct3[2] && funct3[1];
      div_zero = is_div && (b == '0);
      div_ovf  = is_div && !funct3[0] && (a == MIN_NEG) && (b == '1);
`ifdef MULDIV_FAST_MUL_EN
      special  = div_zero || div_ovf || !is_div;
`else
      special  = div_zero || div_ovf;
`endif
   end

   // One iteration step: multiplier/quotient bits shift through the low half of acc
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
      mul_next  = {mul_sum, acc_q[XLEN-1:1]};
      div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_ge    = div_shift >= {1'b0, opnd_q};
      div_next  = div_ge ? {div_shift[XLEN-1:0] - opnd_q, acc_q[XLEN-2:0], 1'b1}
                         : {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = special ? FINISH : CALC;
         CALC:    if (cnt_q == 5'd31) state_d = FINISH;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != IDLE);
   end

   always_comb begin
      cnt_d    = cnt_q;
      op_d     = op_q;
      neg_d    = neg_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      result_d = result_q;
      done_d   = 1'b0;
      prod_fix = neg_q ? neg_2w(acc_q) : acc_q;
      div_half = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
      case (state_q)
         IDLE: begin
            if (start) begin
               op_d   = funct3;
               cnt_d  = '0;
               opnd_d = is_div ? b_mag : a_mag;
               neg_d  = is_rem ? a_neg : (a_neg ^ b_neg);
               acc_d  = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
               // Special results are preloaded as {remainder, quotient} with no sign fix
               if (div_zero) begin
                  acc_d = {a, {XLEN{1'b1}}};
                  neg_d = 1'b0;
               end else if (div_ovf) begin
                  acc_d = {{XLEN{1'b0}}, MIN_NEG};
                  neg_d = 1'b0;
               end
`ifdef MULDIV_FAST_MUL_EN
               else if (!is_div) begin
                  acc_d = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
               end
`endif
            end
         end
         CALC: begin
            cnt_d = cnt_q + 5'd1;
            acc_d = op_q[2] ? div_next : mul_next;
         end
         FINISH: begin
            done_d = 1'b1;
            if (!op_q[2]) result_d = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
            else          result_d = neg_q ? neg_w(div_half) : div_half;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         opnd_q   <= '0;
         acc_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: arithmetic vectors, special cases, handshake, async reset.
module tb_muldiv_unit;

   logic        clk, rst, start;
   logic [2:0]  funct3;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] result;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif

   muldiv_unit #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .start(start), .funct3(funct3),
      .a(a), .b(b), .busy(busy), .done(done), .result(result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Waits for done starting k0 edges after acceptance; returns the edge count or -1 on timeout
   task automatic wait_done(input int k0, output int lat);
      int k;
      logic got;
      k = k0;
      got = 1'b0;
      while (!got && k < 45) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         got = done;
      end
      lat = got ? k : -1;
   endtask

   // Called while the DUT is idle (or in its done cycle); returns at the negedge where done is seen
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] exp_res, input int exp_lat);
      int lat;
      funct3 = f3;
      a      = av;
      b      = bv;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      a      = $urandom;
      b      = $urandom;
      funct3 = f3 ^ 3'b101;
      @(negedge clk);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      wait_done(0, lat);
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_res"}, result, exp_res);
      chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int ndone;
      rst = 1'b1; start = 1'b0; funct3 = 3'b000; a = '0; b = '0;
      #12;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_result", result, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
      @(negedge clk);
      chk("done_pulse", {31'd0, done}, 32'd0);
      chk("result_hold", result, 32'hFFFFFFEB);
      run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT);
      run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
      run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, MUL_LAT);
      run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
      run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
      run_op("divu",   3'b101, 32'd100,      32'd7,        32'd14,       33);
      run_op("remu",   3'b111, 32'd100,      32'd7,        32'd2,        33);
      run_op("div0",   3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
      run_op("remu0",  3'b111, 32'd5,        32'd0,        32'd5,        1);
      run_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      run_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

      // Back-to-back: second start is driven during the first op's done cycle
      run_op("b2b_a",  3'b111, 32'd100,      32'd7,        32'd2,        33);
      run_op("b2b_b",  3'b101, 32'd100,      32'd7,        32'd14,       33);

      // Start pulsed again mid-CALC with different operands must be ignored
      @(negedge clk);
      funct3 = 3'b110; a = 32'd100; b = 32'hFFFFFFF9; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      funct3 = 3'b000; a = 32'd3; b = 32'd3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(6, lat);
      chk("midstart_lat", lat, 32'd33);
      chk("midstart_res", result, 32'd2);
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("midstart_nodone", ndone, 32'd0);
      chk("midstart_hold", result, 32'd2);

      // Asynchronous reset while the counter is at 10
      funct3 = 3'b101; a = 32'd1000; b = 32'd3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_done", {31'd0, done}, 32'd0);
      chk("arst_result", result, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("arst_nodone", ndone, 32'd0);
      chk("arst_idle", {31'd0, busy}, 32'd0);
      run_op("post_rst", 3'b101, 32'd1000, 32'd3, 32'd333, 33);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
